// File: rtl/ifid_bubble.sv
// IF/ID pipeline register with hazard-driven bubble injection and stall-limit monitoring.
// Latency: one cycle from Instr_in/PC_in to Instr_out/PC_out; every output is a flop or comes straight from one.
// Backpressure: no handshake. A NOP/PcStall request replaces the fetched word with NOP_INSTR and holds PC_out.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset; overrides every other input
//   Instr_in   instruction word from fetch
//   PC_in      incremented PC (PC+2) from fetch
//   NOP        hazard detector asks to block this cycle's fetched instruction
//   PcStall    hazard detector asks to hold the PC, so the same instruction is fetched again
//   Instr_out  instruction presented to decode
//   PC_out     PC presented to decode
//   valid_out  1 when Instr_out is a real fetched instruction
//   bubble     1 when Instr_out is the injected NOP_INSTR; always ~valid_out
//   stall_cnt  number of consecutive stall cycles; saturates at MAX_STALL
//   err        set when a stall is requested with stall_cnt already at MAX_STALL; cleared only by reset

module ifid_bubble #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          MAX_STALL = 7          // legal range 1..7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Instr_in,
  input  logic [15:0] PC_in,
  input  logic        NOP,
  input  logic        PcStall,
  output logic [15:0] Instr_out,
  output logic [15:0] PC_out,
  output logic        valid_out,
  output logic        bubble,
  output logic [2:0]  stall_cnt,
  output logic        err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_STALL);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q,    pc_d;
  logic        valid_q, valid_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        err_q,   err_d;

  // PcStall on its own still has to block the fetched word: a refetch of the
  // same instruction is coming, so letting this copy through would execute it twice.
  logic kill;
  logic hold;

  assign kill = NOP | PcStall;
  assign hold = PcStall;

  // ------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      instr_q <= NOP_INSTR;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic. The request alone decides where we go; the current
  // state only matters to the counter below.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = S_RUN;
    if (kill) begin
      if (hold) begin
        state_d = S_STALL;
      end else begin
        state_d = S_FLUSH;
      end
    end
  end

  // ------------------------------------------------------------------
  // Next values for the registered outputs
  // ------------------------------------------------------------------
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_d)
      S_RUN: begin
        // Leaving STALL/FLUSH picks up the current fetch on the same edge,
        // so no extra bubble appears after a hazard clears.
        instr_d = Instr_in;
        pc_d    = PC_in;
        valid_d = 1'b1;
        cnt_d   = 3'd0;
      end

      S_STALL: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        // The count is only nonzero while already in STALL. Coming from
        // RUN or FLUSH, the run starts over at 1.
        if (state_q == S_STALL) begin
          if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 3'd1;
          end
          if (cnt_q == MAX_CNT) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = 3'd1;
        end
      end

      S_FLUSH: begin
        // Branch shadow. Any number of these in a row is legal and never
        // counts toward the stall limit.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        cnt_d   = 3'd0;
      end

      default: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs: driven only from flops. bubble is decoded from the valid
  // register, never from the NOP pin.
  // ------------------------------------------------------------------
  assign Instr_out = instr_q;
  assign PC_out    = pc_q;
  assign valid_out = valid_q;
  assign bubble    = ~valid_q;
  assign stall_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ifid_bubble.sv
module tb_ifid_bubble;

  localparam logic [15:0] NOP_W = 16'h0800;
  localparam int          MAXS  = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Instr_in;
  logic [15:0] PC_in;
  logic        NOP;
  logic        PcStall;
  logic [15:0] Instr_out;
  logic [15:0] PC_out;
  logic        valid_out;
  logic        bubble;
  logic [2:0]  stall_cnt;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  ifid_bubble #(.NOP_INSTR(NOP_W), .MAX_STALL(MAXS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Instr_in (Instr_in),
    .PC_in    (PC_in),
    .NOP      (NOP),
    .PcStall  (PcStall),
    .Instr_out(Instr_out),
    .PC_out   (PC_out),
    .valid_out(valid_out),
    .bubble   (bubble),
    .stall_cnt(stall_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks the length of the current run of stall
  // requests as an unbounded integer. The visible counter is that length
  // clipped to the limit. A stall request made once the run has reached
  // the limit is a violation.
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;
  int          m_run;
  logic        m_err;

  function automatic logic [37:0] model_vec();
    int c;
    c = (m_run > MAXS) ? MAXS : m_run;
    return {m_instr, m_pc, m_valid, ~m_valid, 3'(c), m_err};
  endfunction

  function automatic logic [37:0] dut_vec();
    return {Instr_out, PC_out, valid_out, bubble, stall_cnt, err};
  endfunction

  task automatic model_edge(input logic r, input logic nop, input logic pcs,
                            input logic [15:0] ins, input logic [15:0] pc);
    if (!r) begin
      m_instr = NOP_W; m_pc = 16'h0000; m_valid = 1'b0; m_run = 0; m_err = 1'b0;
    end else if (!(nop || pcs)) begin
      m_instr = ins; m_pc = pc; m_valid = 1'b1; m_run = 0;
    end else begin
      m_instr = NOP_W; m_valid = 1'b0;
      if (pcs) begin
        if (m_run >= MAXS) m_err = 1'b1;
        m_run = m_run + 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One rising edge with the currently driven inputs. Outputs are sampled 1ns later.
  task automatic step();
    model_edge(rst_n, NOP, PcStall, Instr_in, PC_in);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nop, input logic pcs, input logic [15:0] ins,
                       input logic [15:0] pc);
    NOP = nop; PcStall = pcs; Instr_in = ins; PC_in = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------
  task automatic test_reset();
    logic [37:0] exp;
    drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    do_reset();
    exp = {NOP_W, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_basic_stall();
    logic [37:0] exp;
    do_reset();
    drive(1'b0, 1'b0, 16'h4123, 16'h0002);
    step();
    exp = {16'h4123, 16'h0002, 1'b1, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL first_latch: got %h expected %h", dut_vec(), exp);
    end
    drive(1'b1, 1'b1, 16'h5555, 16'h0004);
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {NOP_W, 16'h0002, 1'b0, 1'b1, 3'(i), 1'b0};
      n_checks++;
      if (dut_vec() !== exp) begin
        n_fail++;
        $display("FAIL stall_edge%0d: got %h expected %h", i, dut_vec(), exp);
      end
    end
    drive(1'b0, 1'b0, 16'h5555, 16'h0004);
    step();
    exp = {16'h5555, 16'h0004, 1'b1, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL stall_release: got %h expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 1'b1, 16'h1234, 16'h0010);
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++;
      if (stall_cnt !== 3'((i > 7) ? 7 : i) || err !== (i == 8)) begin
        n_fail++;
        $display("FAIL saturate_edge%0d: got cnt=%0d err=%b expected cnt=%0d err=%b",
                 i, stall_cnt, err, (i > 7) ? 7 : i, (i == 8));
      end
    end
    drive(1'b0, 1'b0, 16'h2222, 16'h0012);
    step();
    n_checks++;
    if (err !== 1'b1 || stall_cnt !== 3'd0 || Instr_out !== 16'h2222) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b cnt=%0d instr=%h expected err=1 cnt=0 instr=2222",
               err, stall_cnt, Instr_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b0, 1'b0, 16'hA001, 16'h0020);
    step();
    drive(1'b1, 1'b0, 16'hA002, 16'h0022);
    step();
    n_checks++;
    if ({Instr_out, PC_out, valid_out, bubble, stall_cnt} !== {NOP_W, 16'h0020, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL flush_bubble: got instr=%h pc=%h v=%b b=%b cnt=%0d expected 0800 0020 0 1 0",
               Instr_out, PC_out, valid_out, bubble, stall_cnt);
    end
    drive(1'b0, 1'b0, 16'hA003, 16'h0024);
    step();
    n_checks++;
    if ({Instr_out, PC_out, valid_out, bubble} !== {16'hA003, 16'h0024, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_release: got instr=%h pc=%h v=%b b=%b expected a003 0024 1 0",
               Instr_out, PC_out, valid_out, bubble);
    end
  endtask

  task automatic test_pcstall_only();
    do_reset();
    drive(1'b0, 1'b0, 16'h4123, 16'h0002);
    step();
    drive(1'b0, 1'b1, 16'h5555, 16'h0004);
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (dut_vec() !== {NOP_W, 16'h0002, 1'b0, 1'b1, 3'(i), 1'b0}) begin
        n_fail++;
        $display("FAIL pcstall_only_edge%0d: got %h expected %h", i, dut_vec(),
                 {NOP_W, 16'h0002, 1'b0, 1'b1, 3'(i), 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 16'h7777, 16'h0030);
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if ({valid_out, bubble, stall_cnt, err} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_back_flush: got v=%b b=%b cnt=%0d err=%b expected 0 1 0 0",
               valid_out, bubble, stall_cnt, err);
    end
    drive(1'b1, 1'b1, 16'h7777, 16'h0030);
    step();
    n_checks++;
    if (stall_cnt !== 3'd1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_to_stall: got cnt=%0d err=%b expected cnt=1 err=0", stall_cnt, err);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 1'b1, 16'h3333, 16'h0040);
    for (int i = 0; i < 8; i++) step();
    drive(1'b0, 1'b0, 16'h3334, 16'h0042);
    step();
    drive(1'b1, 1'b1, 16'h3335, 16'h0044);
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (err !== 1'b1 || stall_cnt !== 3'd5) begin
      n_fail++;
      $display("FAIL pre_reset_stall: got err=%b cnt=%0d expected err=1 cnt=5", err, stall_cnt);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (dut_vec() !== {NOP_W, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got %h expected %h", dut_vec(),
               {NOP_W, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0});
    end
    // Reset released with a stall still requested: the first edge after it is an ordinary stall.
    step();
    n_checks++;
    if (stall_cnt !== 3'd1 || valid_out !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_stall: got cnt=%0d v=%b err=%b expected 1 0 0",
               stall_cnt, valid_out, err);
    end
  endtask

  task automatic test_random();
    int burst = 0;
    int kind  = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0) begin
        kind  = $urandom_range(0, 4);
        burst = $urandom_range(1, 10);
      end
      burst--;
      Instr_in = 16'($urandom);
      PC_in    = 16'($urandom);
      case (kind)
        0: begin NOP = 1'b0; PcStall = 1'b0; end
        1: begin NOP = 1'b1; PcStall = 1'b1; end
        2: begin NOP = 1'b0; PcStall = 1'b1; end
        3: begin NOP = 1'b1; PcStall = 1'b0; end
        default: begin NOP = 1'($urandom); PcStall = 1'($urandom); end
      endcase
      rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    m_instr = NOP_W; m_pc = 16'h0000; m_valid = 1'b0; m_run = 0; m_err = 1'b0;
    test_reset();
    test_basic_stall();
    test_saturation();
    test_flush();
    test_pcstall_only();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_bubble.md
IFID_BUBBLE -- requirements
Module: ifid_bubble

Interface
REQ-001 Parameter NOP_INSTR, default 16'h0800, SHALL be the instruction word injected as a bubble.
REQ-002 Parameter MAX_STALL, default 7, SHALL be the consecutive-stall limit; legal range 1..7.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 Instr_in  input  16  instruction word from fetch.
REQ-006 PC_in  input  16  incremented PC (PC+2) from fetch.
REQ-007 NOP  input  1  hazard-detector request to block the fetched instruction this cycle.
REQ-008 PcStall  input  1  hazard-detector request to hold the PC (same instruction refetched).
REQ-009 Instr_out  output  16  IF/ID instruction presented to decode.
REQ-010 PC_out  output  16  IF/ID PC presented to decode.
REQ-011 valid_out  output  1  1 = Instr_out is a real fetched instruction.
REQ-012 bubble  output  1  1 = Instr_out is an injected NOP_INSTR; always equals ~valid_out.
REQ-013 stall_cnt  output  3  consecutive stall cycles, saturating.
REQ-014 err  output  1  sticky stall-limit violation flag.

Function
REQ-015 Block SHALL be the receiving end of the hazard-detector request pair: an IF/ID register with bubble injection, one-cycle latency Instr_in -> Instr_out.
REQ-016 Effective request SHALL be: kill = NOP | PcStall; hold = PcStall (PcStall without NOP is treated as NOP plus stall).
REQ-017 State machine SHALL have three states: RUN, STALL, FLUSH; encoding free.
REQ-018 Any state, kill=0 at edge: Instr_out<=Instr_in, PC_out<=PC_in, valid_out<=1, stall_cnt<=0, next state RUN.
REQ-019 Any state, kill=1 and hold=1 at edge: Instr_out<=NOP_INSTR, valid_out<=0, PC_out holds previous value, next state STALL.
REQ-020 Any state, kill=1 and hold=0 at edge (branch/jump shadow): Instr_out<=NOP_INSTR, valid_out<=0, PC_out holds, stall_cnt<=0, next state FLUSH.
REQ-021 Entering or remaining in STALL SHALL increment stall_cnt by 1, saturating at MAX_STALL (no wrap).
REQ-022 If hold=1 at an edge while stall_cnt==MAX_STALL, err SHALL be set to 1 and remain 1 until reset.
REQ-023 FLUSH -> STALL with hold=1 SHALL start stall_cnt at 1 (counter cleared in FLUSH).
REQ-024 Back-to-back FLUSH (kill=1, hold=0 on consecutive edges) SHALL inject one bubble per edge with no limit and no err.
REQ-025 Leaving STALL or FLUSH with kill=0 SHALL latch the current Instr_in/PC_in in the same edge (no extra bubble).
REQ-026 Outputs SHALL be registered only; no combinational path from any input to any output.
REQ-027 bubble SHALL be generated from state registers, never from the NOP input directly.

Reset
REQ-028 rst_n=0 at an edge SHALL force: Instr_out=NOP_INSTR, PC_out=16'h0000, valid_out=0, bubble=1, stall_cnt=0, err=0, state RUN.
REQ-029 Reset SHALL take priority over NOP/PcStall, including mid-STALL and when err=1.
REQ-030 First edge with rst_n=1 SHALL follow REQ-018..REQ-020 normally.

Verification
REQ-031 Reset, then Instr_in=16'h4123, PC_in=16'h0002, NOP=0 one edge -> Instr_out=16'h4123, PC_out=16'h0002, valid_out=1, bubble=0.
REQ-032 After REQ-031, NOP=1,PcStall=1 for 3 edges with Instr_in=16'h5555 -> Instr_out=16'h0800, PC_out=16'h0002, stall_cnt=1,2,3, err=0; then NOP=0 -> Instr_out=16'h5555, stall_cnt=0.
REQ-033 NOP=1,PcStall=1 for 8 consecutive edges (MAX_STALL=7) -> stall_cnt saturates at 7, err=1 after 8th edge, err stays 1 after NOP=0.
REQ-034 NOP=1,PcStall=0 one edge then NOP=0 -> exactly one bubble (valid_out 0 for one cycle), then new Instr_in latched.
REQ-035 PcStall=1,NOP=0 -> identical response to NOP=1,PcStall=1.
REQ-036 rst_n=0 asserted with err=1 and stall_cnt=5 in STALL -> next edge all outputs at REQ-028 values.
